// File: rtl/shift_universal.sv
// Parametrised universal shift register: hold, shift-up, shift-down, parallel load,
// with a saturating shift counter that flags a full word shifted since the last load/reset.
module shift_universal #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             cp,
  input  logic             mr,
  input  logic [1:0]       s,
  input  logic             dsa,
  input  logic             dsb,
  input  logic             dsl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_up,
  output logic             q_dn,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  // Either shift direction advances the counter; it parks at WIDTH.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    case (s)
      MODE_HOLD: begin
        q_d   = q_q;
        cnt_d = cnt_q;
      end
      MODE_UP: begin
        q_d   = {q_q[WIDTH-2:0], dsa & dsb};
        cnt_d = cnt_inc;
      end
      MODE_DN: begin
        q_d   = {dsl, q_q[WIDTH-1:1]};
        cnt_d = cnt_inc;
      end
      MODE_LOAD: begin
        q_d   = d;
        cnt_d = '0;
      end
      default: begin
        q_d   = q_q;
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge cp or posedge mr) begin
    if (mr) begin
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q    = q_q;
  assign q_up = q_q[WIDTH-1];
  assign q_dn = q_q[0];
  assign cnt  = cnt_q;
  assign tc   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_shift_universal.sv
// Directed bench for shift_universal (WIDTH=8): reset, shifting both ways,
// saturation, hold, mid-word reset and serial outputs.
module tb_shift_universal;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             cp;
  logic             mr;
  logic [1:0]       s;
  logic             dsa;
  logic             dsb;
  logic             dsl;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             q_up;
  logic             q_dn;
  logic [CNT_W-1:0] cnt;
  logic             tc;

  int tests_run;
  int tests_failed;

  logic [WIDTH-1:0] exp_q[$];

  shift_universal #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .cp   (cp),
    .mr   (mr),
    .s    (s),
    .dsa  (dsa),
    .dsb  (dsb),
    .dsl  (dsl),
    .d    (d),
    .q    (q),
    .q_up (q_up),
    .q_dn (q_dn),
    .cnt  (cnt),
    .tc   (tc)
  );

  // clock / reset
  initial begin
    cp = 1'b0;
    forever #5 cp = ~cp;
  end

  initial begin
    mr  = 1'b1;
    s   = 2'b11;
    dsa = 1'b0;
    dsb = 1'b0;
    dsl = 1'b0;
    d   = 8'hFF;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle between edges, then check q/cnt/tc just after the rising edge.
  task automatic step(input string tag, input logic [1:0] s_v, input logic a_v,
                      input logic b_v, input logic l_v, input logic [WIDTH-1:0] d_v,
                      input logic [WIDTH-1:0] eq, input logic [CNT_W-1:0] ec);
    logic [WIDTH-1:0] e;
    @(negedge cp);
    s   = s_v;
    dsa = a_v;
    dsb = b_v;
    dsl = l_v;
    d   = d_v;
    exp_q.push_back(eq);
    @(posedge cp);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_q"}, 32'(q), 32'(e));
    chk({tag, "_cnt"}, 32'(cnt), 32'(ec));
    chk({tag, "_tc"}, 32'(tc), 32'(ec == CNT_W'(WIDTH)));
  endtask

  task automatic load(input string tag, input logic [WIDTH-1:0] d_v);
    step(tag, 2'b11, 1'b0, 1'b0, 1'b0, d_v, d_v, 4'd0);
  endtask

  logic [WIDTH-1:0] up_vec[5] = '{8'h01, 8'h03, 8'h06, 8'h0C, 8'h19};
  logic             up_a[5]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [WIDTH-1:0] dn_vec[8] = '{8'hD2, 8'hE9, 8'hF4, 8'hFA, 8'hFD, 8'hFE, 8'hFF, 8'hFF};

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // 1: reset held through several edges with load requested
    for (int i = 0; i < 3; i++) begin
      @(posedge cp);
      #1;
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_cnt", 32'(cnt), 32'h0);
      chk("rst_tc", 32'(tc), 32'h0);
    end
    @(posedge cp);
    mr <= 1'b0;
    #1;
    chk("rel_edge_q", 32'(q), 32'h0);
    @(posedge cp);
    #1;
    chk("rel_next_q", 32'(q), 32'hFF);

    // 2: shift-up with gated serial input
    load("ld00", 8'h00);
    for (int i = 0; i < 5; i++)
      step("up", 2'b01, up_a[i], 1'b1, 1'b0, 8'h00, up_vec[i], CNT_W'(i + 1));
    step("up_gate", 2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 8'h32, 4'd6);

    // 3: shift-down to saturation
    load("ldA5", 8'hA5);
    for (int i = 0; i < 8; i++)
      step("dn", 2'b10, 1'b0, 1'b0, 1'b1, 8'h00, dn_vec[i], CNT_W'(i + 1));
    step("dn_sat", 2'b10, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 4'd8);

    // 4: hold with other inputs moving
    for (int i = 0; i < 4; i++)
      step("hold", 2'b00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'hFF, 4'd8);

    // 5: asynchronous reset mid-word
    load("ld00b", 8'h00);
    for (int i = 0; i < 3; i++)
      step("pre_rst", 2'b01, 1'b1, 1'b1, 1'b0, 8'h00, 8'((1 << (i + 1)) - 1), CNT_W'(i + 1));
    @(negedge cp);
    #2;
    mr = 1'b1;
    #1;
    chk("async_q", 32'(q), 32'h0);
    chk("async_cnt", 32'(cnt), 32'h0);
    @(negedge cp);
    mr = 1'b0;
    load("ld3C", 8'h3C);

    // 6: serial outputs
    load("ld81", 8'h81);
    chk("qup_before", 32'(q_up), 32'h1);
    step("up0", 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 4'd1);
    chk("qup_after", 32'(q_up), 32'h0);
    step("dn0a", 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 4'd2);
    chk("qdn_a", 32'(q_dn), 32'h1);
    step("dn0b", 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd3);
    chk("qdn_b", 32'(q_dn), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
